// File: rtl/da_pkg.sv
// Shared types and default sizing for the distributed-arithmetic FIR sequencer.
// TAPS is derived from LUT_GROUPS and GROUP_W.
package da_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int LUT_GROUPS_DEF = 8;
  localparam int GROUP_W_DEF    = 4;
  localparam int TAPS_DEF       = LUT_GROUPS_DEF * GROUP_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE,
    HOLD
  } state_e;

endpackage

// File: rtl/da_tap_shreg.sv
// TAPS-deep sample delay line (tap 0 newest) with synchronous clear,
// plus the bit-plane select that forms the LUT address bits.
module da_tap_shreg #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk3,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              sel_i,
  input  logic [IDX_W-1:0]  bit_idx_i,
  output logic [TAPS-1:0]   addr_o
);

  logic [DATA_W-1:0] taps_q [TAPS];

  always_ff @(posedge clk3) begin
    if (clr_i) begin
      for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
    end else if (shift_i) begin
      taps_q[0] <= din_i;
      for (int i = 1; i < TAPS; i++) taps_q[i] <= taps_q[i-1];
    end
  end

  always_comb begin
    addr_o = '0;
    if (sel_i) begin
      for (int i = 0; i < TAPS; i++) addr_o[i] = taps_q[i][bit_idx_i];
    end
  end

endmodule

// File: rtl/da_sequencer.sv
// Bit-serial DA FIR control sequencer: sample intake, MSB-first bit-planes,
// result load and output hold. Optional perf counters: DA_SEQ_PERF_EN.
module da_sequencer
  import da_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LUT_GROUPS = LUT_GROUPS_DEF,
  parameter int GROUP_W    = GROUP_W_DEF
) (
  input  logic                          clk3,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic [LUT_GROUPS*GROUP_W-1:0] lut_addr,
  output logic                          acc_clr,
  output logic                          acc_en,
  output logic                          acc_sub,
  output logic                          sum_load,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
`ifdef DA_SEQ_PERF_EN
  ,
  output logic [15:0]                   sample_cnt,
  output logic [15:0]                   stall_cnt
`endif
);

  localparam int TAPS  = LUT_GROUPS * GROUP_W;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] MSB = IDX_W'(DATA_W - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic             accept;

  always_ff @(posedge clk3) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= MSB;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    acc_en    = 1'b0;
    acc_clr   = 1'b0;
    acc_sub   = 1'b0;
    sum_load  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          accept    = 1'b1;
          bit_idx_d = MSB;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        acc_en  = 1'b1;
        // Sign plane comes first and carries negative weight
        acc_clr = (bit_idx_q == MSB);
        acc_sub = (bit_idx_q == MSB);
        if (bit_idx_q == '0) state_d = DONE;
        else bit_idx_d = bit_idx_q - IDX_W'(1);
      end
      DONE: begin
        sum_load = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  da_tap_shreg #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .IDX_W  (IDX_W)
  ) u_taps (
    .clk3      (clk3),
    .clr_i     (reset),
    .shift_i   (accept),
    .din_i     (in_data),
    .sel_i     (state_q == ACCUM),
    .bit_idx_i (bit_idx_q),
    .addr_o    (lut_addr)
  );

`ifdef DA_SEQ_PERF_EN
  logic [15:0] sample_cnt_q, stall_cnt_q;

  always_ff @(posedge clk3) begin
    if (reset) begin
      sample_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (accept && sample_cnt_q != 16'hFFFF)
        sample_cnt_q <= sample_cnt_q + 16'd1;
      if (state_q == HOLD && !out_ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_da_sequencer.sv
// Directed self-checking bench for da_sequencer.
// Define DA_SEQ_PERF_EN to also exercise the perf counters.
module tb_da_sequencer;

  logic        clk3;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [31:0] lut_addr;
  logic        acc_clr;
  logic        acc_en;
  logic        acc_sub;
  logic        sum_load;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
`ifdef DA_SEQ_PERF_EN
  logic [15:0] sample_cnt;
  logic [15:0] stall_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  da_sequencer dut (
    .clk3      (clk3),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .lut_addr  (lut_addr),
    .acc_clr   (acc_clr),
    .acc_en    (acc_en),
    .acc_sub   (acc_sub),
    .sum_load  (sum_load),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef DA_SEQ_PERF_EN
    ,
    .sample_cnt(sample_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk3 = 1'b0;
  always #5 clk3 = ~clk3;

  task automatic tick;
    @(posedge clk3);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept d from IDLE, consume immediately, return in IDLE (T+19)
  task automatic push(input logic [15:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (18) tick;
    chk("push_idle", {31'd0, in_ready}, 32'd1);
  endtask

`ifdef DA_SEQ_PERF_EN
  task automatic stall_sample(input logic [15:0] d, input int s);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    repeat (17) tick;
    repeat (s) tick;
    out_ready = 1'b1;
    tick;
  endtask
`endif

  initial begin
    logic [31:0] e1, e0;
    int v, cnt, ld, ov;
    int acc_t[$];

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick;
    tick;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_lut", lut_addr, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    tick;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Test 1: 16'h8001 timing
    in_valid = 1'b1;
    in_data  = 16'h8001;
    tick;
    in_valid = 1'b0;
    chk("t1_lut_first", lut_addr, 32'h1);
    chk("t1_clr", {31'd0, acc_clr}, 32'd1);
    chk("t1_sub", {31'd0, acc_sub}, 32'd1);
    chk("t1_en", {31'd0, acc_en}, 32'd1);
    for (int k = 2; k <= 15; k++) begin
      tick;
      chk("t1_lut_mid", lut_addr, 32'h0);
      chk("t1_clr_mid", {31'd0, acc_clr}, 32'd0);
      chk("t1_en_mid", {31'd0, acc_en}, 32'd1);
    end
    tick;
    chk("t1_lut_last", lut_addr, 32'h1);
    chk("t1_sub_last", {31'd0, acc_sub}, 32'd0);
    tick;
    chk("t1_sum_load", {31'd0, sum_load}, 32'd1);
    chk("t1_en_off", {31'd0, acc_en}, 32'd0);
    chk("t1_lut_off", lut_addr, 32'h0);
    tick;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_sum_once", {31'd0, sum_load}, 32'd0);

    // Test 2: backpressure with in_valid offered
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("t2_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("t2_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("t2_valid_drop", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0000;
    tick;
    in_valid = 1'b0;
    chk("t2_no_accept", lut_addr, 32'h2);
    repeat (18) tick;
    chk("t2_back_idle", {31'd0, in_ready}, 32'd1);

    // Test 3: 33 samples, last pass taps 31..0 = 2..33
    for (int s = 1; s <= 32; s++) push(16'(s));
    for (int j = 0; j < 32; j++) begin
      v = 33 - j;
      e1[j] = v[1];
      e0[j] = v[0];
    end
    in_valid = 1'b1;
    in_data  = 16'd33;
    tick;
    in_valid = 1'b0;
    repeat (14) tick;
    chk("t3_plane1", lut_addr, e1);
    chk("t3_tap31_b1", {31'd0, lut_addr[31]}, 32'd1);
    tick;
    chk("t3_plane0", lut_addr, e0);
    tick;
    chk("t3_sum_load", {31'd0, sum_load}, 32'd1);
    tick;
    tick;
    chk("t3_idle", {31'd0, in_ready}, 32'd1);

    // Test 4: reset during 5th ACCUM cycle
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    chk("t4_pre_en", {31'd0, acc_en}, 32'd1);
    reset = 1'b1;
    tick;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_en", {31'd0, acc_en}, 32'd0);
    chk("t4_lut", lut_addr, 32'd0);
    chk("t4_sum", {31'd0, sum_load}, 32'd0);
    chk("t4_ov", {31'd0, out_valid}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      cnt += int'(sum_load) + int'(out_valid);
    end
    chk("t4_no_pending", cnt, 32'd0);
    chk("t4_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 16'h8000;
    tick;
    in_valid = 1'b0;
    chk("t4_line_clear", lut_addr, 32'h1);
    repeat (18) tick;
    chk("t4_back_idle", {31'd0, in_ready}, 32'd1);

    // Test 5: streaming at minimum period
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    out_ready = 1'b1;
    ld = 0;
    ov = 0;
    for (int c = 0; c < 57; c++) begin
      if (in_ready) acc_t.push_back(c);
      ld += int'(sum_load);
      ov += int'(out_valid);
      tick;
    end
    in_valid = 1'b0;
    chk("t5_accepts", acc_t.size(), 32'd3);
    chk("t5_first", (acc_t.size() > 0) ? acc_t[0] : -1, 32'd0);
    chk("t5_gap1", (acc_t.size() > 1) ? acc_t[1] - acc_t[0] : -1, 32'd19);
    chk("t5_gap2", (acc_t.size() > 2) ? acc_t[2] - acc_t[1] : -1, 32'd19);
    chk("t5_loads", ld, 32'd3);
    chk("t5_valids", ov, 32'd3);

`ifdef DA_SEQ_PERF_EN
    // Test 6: perf counters
    reset = 1'b1;
    tick;
    chk("t6_rst_smp", {16'd0, sample_cnt}, 32'd0);
    chk("t6_rst_stl", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    tick;
    stall_sample(16'h0011, 2);
    stall_sample(16'h0022, 0);
    stall_sample(16'h0033, 2);
    chk("t6_samples", {16'd0, sample_cnt}, 32'd3);
    chk("t6_stalls", {16'd0, stall_cnt}, 32'd4);
    reset = 1'b1;
    tick;
    chk("t6_clr_smp", {16'd0, sample_cnt}, 32'd0);
    chk("t6_clr_stl", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b0;
    tick;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/da_sequencer.md
# da_sequencer

Control sequencer for the bit-serial distributed-arithmetic FIR datapath on the `clk3` domain. It accepts input samples through a valid/ready handshake and keeps the TAPS-deep sample delay line. For each sample it drives the LUT address bits one bit-plane per cycle, MSB first, together with the accumulator clear, enable and subtract strobes. It then issues the result-register load and holds the output handshake until the result is consumed.

## Interface
Parameters:
- DATA_W, 16: sample width; also the number of bit-serial accumulate cycles.
- LUT_GROUPS, 8: number of LUTs in the datapath.
- GROUP_W, 4: LUT address width per group. TAPS = LUT_GROUPS*GROUP_W (32).

Ports (one clock `clk3`; `reset` is synchronous and active-high):
- clk3, in, 1: datapath clock.
- reset, in, 1: synchronous, active-high reset.
- in_valid, in, 1: a sample is offered.
- in_ready, out, 1: the sequencer can accept a sample.
- in_data, in, DATA_W: sample, two's complement.
- lut_addr, out, TAPS: bit g*GROUP_W+j = bit `bit_idx` of tap g*GROUP_W+j. Tap 0 is the newest sample.
- acc_clr, out, 1: datapath drops the 2*acc feedback term this cycle.
- acc_en, out, 1: datapath accumulator updates this cycle.
- acc_sub, out, 1: datapath negates the LUT sum this cycle (sign bit-plane).
- sum_load, out, 1: datapath result register captures the accumulator.
- out_valid, out, 1: the result register holds an unconsumed result.
- out_ready, in, 1: downstream accepts the result.
- busy, out, 1: state is not IDLE.

## Operation
- States: IDLE, ACCUM, DONE, HOLD.
- IDLE: in_ready=1.
  - On in_valid&&in_ready: shift in_data into tap 0 (tap 31 is dropped), set bit_idx=DATA_W-1, go to ACCUM.
- ACCUM: acc_en=1 for DATA_W cycles.
  - First cycle: acc_clr=1 and acc_sub=1 (sign bit, negative weight).
  - bit_idx decrements each cycle. From bit_idx=0, go to DONE.
- DONE: sum_load=1 for one cycle, then go to HOLD.
- HOLD: out_valid=1.
  - On out_valid&&out_ready: go to IDLE.
- in_valid outside IDLE is ignored. The delay line is unchanged and in_data is not sampled.
- out_ready outside HOLD has no effect.
- lut_addr is registered from the delay line and bit_idx. It is 0 outside ACCUM.
- bit_idx counter width is clog2(DATA_W). It never wraps below 0; ACCUM exits at 0.
- Arithmetic contract with the datapath: acc ← (acc_clr ? 0 : 2*acc) + (acc_sub ? −L : L), where L is the sum of the LUT outputs. This yields the exact signed dot product after DATA_W cycles.

## Timing
- Reset values: in_ready=0 while reset is high, and 1 on the first cycle after release. All other outputs are 0, the delay line is 0, state=IDLE, bit_idx=DATA_W-1.
- Input accepted at cycle T:
  - ACCUM at T+1..T+DATA_W, with acc_clr/acc_sub at T+1.
  - sum_load at T+DATA_W+1.
  - out_valid from T+DATA_W+2.
- Consumption at cycle U means IDLE (in_ready=1) at U+1.
- Minimum sample period with out_ready held at 1: DATA_W+3 cycles (19).
- Reset mid-operation (any state): the next cycle is IDLE with all outputs 0 and the delay line cleared. No pending sum_load or out_valid survives.
- Reset and handshake in the same cycle: reset wins and the sample is dropped.

## Configuration
- `DA_SEQ_PERF_EN` defined: adds two outputs.
  - `sample_cnt[15:0]`: counts accepted samples.
  - `stall_cnt[15:0]`: counts HOLD cycles with out_ready=0.
  - Both saturate at 16'hFFFF and are cleared by reset.
- `DA_SEQ_PERF_EN` undefined: neither port nor its logic exists.

## Structure
- Shared package `da_pkg`:
  - state enum (IDLE/ACCUM/DONE/HOLD)
  - default DATA_W, LUT_GROUPS, GROUP_W
  - derived TAPS constant
- Sub-module `da_tap_shreg`:
  - TAPS×DATA_W delay line with shift enable and synchronous clear.
  - Bit-plane select producing TAPS address bits.
- The sequencer FSM and counters stay in the top module.

## Test plan
1. After reset, accept 16'h8001 at T (delay line otherwise 0):
   - lut_addr[0]=1 at T+1 with acc_clr=acc_sub=1.
   - lut_addr[0]=0 at T+2..T+15 and =1 at T+16.
   - sum_load at T+17, out_valid at T+18.
2. out_ready held 0 for 5 HOLD cycles with in_valid=1:
   - out_valid stays 1, in_ready stays 0, no sample is accepted.
   - After the transfer, in_ready=1 on the next cycle.
3. Push 33 samples 1..33:
   - On the last ACCUM pass, tap 31 = sample 2 and tap 0 = 33.
   - lut_addr[31] at bit_idx=1 equals 1 (sample 2 = 16'h0002).
4. Assert reset at the 5th ACCUM cycle:
   - Next cycle: state IDLE, all outputs 0, delay line 0.
   - No sum_load or out_valid afterwards.
5. in_valid and out_ready held at 1 continuously:
   - Accepts occur exactly 19 cycles apart.
   - sum_load and out_valid occur once per sample.
6. With `DA_SEQ_PERF_EN` defined, 3 samples with 4 total out_ready-low HOLD cycles:
   - sample_cnt=3, stall_cnt=4.
   - Both equal 0 after reset.
